// File: rtl/rho_lane_rotator_pkg.sv
// Shared types and constants for the Keccak rho lane rotator.
// The rho offset table here must stay in sync with the lane offset ROM.
package rho_lane_rotator_pkg;

    localparam int LANE_W  = 64;
    localparam int N_LANES = 25;
    localparam int CNT_W   = 5;
    localparam int OFF_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } rho_state_e;

    // Offsets follow this datapath's lane numbering, not the textbook x+5y order.
    function automatic logic [OFF_W-1:0] rho_offset(input logic [CNT_W-1:0] lane);
        case (lane)
            5'd0:    return 6'd21;
            5'd1:    return 6'd8;
            5'd2:    return 6'd41;
            5'd3:    return 6'd45;
            5'd4:    return 6'd15;
            5'd5:    return 6'd56;
            5'd6:    return 6'd14;
            5'd7:    return 6'd18;
            5'd8:    return 6'd2;
            5'd9:    return 6'd61;
            5'd10:   return 6'd28;
            5'd11:   return 6'd27;
            5'd12:   return 6'd0;
            5'd13:   return 6'd1;
            5'd14:   return 6'd62;
            5'd15:   return 6'd55;
            5'd16:   return 6'd20;
            5'd17:   return 6'd36;
            5'd18:   return 6'd44;
            5'd19:   return 6'd6;
            5'd20:   return 6'd25;
            5'd21:   return 6'd39;
            5'd22:   return 6'd3;
            5'd23:   return 6'd10;
            5'd24:   return 6'd43;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/rho_lane_rotator_barrel.sv
// Combinational 64-bit left rotator, 6-bit amount, built as log2 stages.
module lane_barrel_rotl
    import rho_lane_rotator_pkg::*;
(
    input  logic [LANE_W-1:0] data_in,
    input  logic [OFF_W-1:0]  amount,
    output logic [LANE_W-1:0] data_out
);

    logic [LANE_W-1:0] stage_v;

    always_comb begin
        stage_v = data_in;
        for (int k = 0; k < OFF_W; k++) begin
            if (amount[k]) begin
                stage_v = (stage_v << (1 << k)) | (stage_v >> (LANE_W - (1 << k)));
            end
        end
        data_out = stage_v;
    end

endmodule

// File: rtl/rho_lane_rotator.sv
// Rho step: rotates 25 streamed lanes by their rho offsets and forwards them to pi.
// Optional second output stage selected by defining RHO_OUT_REG_EN.
module rho_lane_rotator
    import rho_lane_rotator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LANE_W-1:0] lane_in,
    input  logic              lane_in_valid,
    output logic              lane_in_ready,
    output logic [LANE_W-1:0] lane_out,
    output logic [CNT_W-1:0]  lane_out_idx,
    output logic              lane_out_valid,
    input  logic              lane_out_ready,
    output logic              busy,
    output logic              done
);

    rho_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LANE_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_idx_q, out_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [LANE_W-1:0] rot_data;
    logic [OFF_W-1:0]  rot_amount;
    logic              accept, out_fire, pipe_empty_d;

    assign rot_amount = rho_offset(cnt_q);

    lane_barrel_rotl u_rotl (
        .data_in  (lane_in),
        .amount   (rot_amount),
        .data_out (rot_data)
    );

    assign accept   = lane_in_valid && lane_in_ready;
    assign out_fire = out_valid_q && lane_out_ready;

`ifdef RHO_OUT_REG_EN
    logic [LANE_W-1:0] mid_data_q, mid_data_d;
    logic [CNT_W-1:0]  mid_idx_q, mid_idx_d;
    logic              mid_valid_q, mid_valid_d;
    logic              mid_adv;

    assign mid_adv       = mid_valid_q && (!out_valid_q || lane_out_ready);
    assign lane_in_ready = (state_q == ST_RUN) && (!mid_valid_q || mid_adv);

    always_comb begin
        mid_data_d  = mid_data_q;
        mid_idx_d   = mid_idx_q;
        mid_valid_d = mid_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (mid_adv) begin
            out_data_d  = mid_data_q;
            out_idx_d   = mid_idx_q;
            out_valid_d = 1'b1;
            mid_valid_d = 1'b0;
        end
        if (accept) begin
            mid_data_d  = rot_data;
            mid_idx_d   = cnt_q;
            mid_valid_d = 1'b1;
        end
        pipe_empty_d = !out_valid_d && !mid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mid_data_q  <= '0;
            mid_idx_q   <= '0;
            mid_valid_q <= 1'b0;
        end else begin
            mid_data_q  <= mid_data_d;
            mid_idx_q   <= mid_idx_d;
            mid_valid_q <= mid_valid_d;
        end
    end
`else
    assign lane_in_ready = (state_q == ST_RUN) && (!out_valid_q || lane_out_ready);

    // Load and drain may happen in the same cycle, keeping one lane per clock.
    always_comb begin
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_data_d  = rot_data;
            out_idx_d   = cnt_q;
            out_valid_d = 1'b1;
        end
        pipe_empty_d = !out_valid_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(N_LANES - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_d) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign lane_out       = out_data_q;
    assign lane_out_idx   = out_idx_q;
    assign lane_out_valid = out_valid_q;
    assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_rho_lane_rotator.sv
// Directed bench for rho_lane_rotator (default build, one-cycle latency).
module tb_rho_lane_rotator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] lane_in;
    logic        lane_in_valid;
    logic        lane_in_ready;
    logic [63:0] lane_out;
    logic [4:0]  lane_out_idx;
    logic        lane_out_valid;
    logic        lane_out_ready;
    logic        busy;
    logic        done;

    rho_lane_rotator dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .lane_in        (lane_in),
        .lane_in_valid  (lane_in_valid),
        .lane_in_ready  (lane_in_ready),
        .lane_out       (lane_out),
        .lane_out_idx   (lane_out_idx),
        .lane_out_valid (lane_out_valid),
        .lane_out_ready (lane_out_ready),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          cnt_model = 0;
    int          out_count = 0;
    int          hs_cyc = -100;
    bit          acc_flag;
    logic [68:0] sb_q[$];
    logic [63:0] lanes[25];
    logic [5:0]  rho_tab[25] = '{6'd21, 6'd8, 6'd41, 6'd45, 6'd15, 6'd56, 6'd14, 6'd18, 6'd2,
                                 6'd61, 6'd28, 6'd27, 6'd0, 6'd1, 6'd62, 6'd55, 6'd20, 6'd36,
                                 6'd44, 6'd6, 6'd25, 6'd39, 6'd3, 6'd10, 6'd43};

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (64 - n));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Samples handshakes just before the edge, feeding/draining the scoreboard.
    task automatic step();
        logic [68:0] e;
        #1;
        acc_flag = lane_in_valid && lane_in_ready;
        if (acc_flag && cnt_model < 25) begin
            sb_q.push_back({cnt_model[4:0], rotl64(lane_in, int'(rho_tab[cnt_model]))});
            cnt_model++;
        end
        if (lane_out_valid && lane_out_ready) begin
            hs_cyc = cyc;
            out_count++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output_idx", {59'd0, lane_out_idx}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", lane_out, e[63:0]);
                check("sb_idx", {59'd0, lane_out_idx}, {59'd0, e[68:64]});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lane_out"}, lane_out, 64'd0);
        check({tag, "_idx"}, {59'd0, lane_out_idx}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, lane_out_valid}, 64'd0);
        check({tag, "_in_ready"}, {63'd0, lane_in_ready}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
    endtask

    // One pass with an optional backpressure window; bounded by a cycle budget.
    task automatic run_pass(input int stall_from, input int stall_len);
        int  li;
        int  done_cnt;
        int  done_cyc;
        bit  stalled_prev;
        logic [63:0] hold_data;
        logic [4:0]  hold_idx;
        li = 0; done_cnt = 0; done_cyc = -1; stalled_prev = 0;
        hold_data = '0; hold_idx = '0;
        out_count = 0; cnt_model = 0; sb_q.delete();
        lane_out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (stalled_prev) begin
                check("stall_hold_data", lane_out, hold_data);
                check("stall_hold_idx", {59'd0, lane_out_idx}, {59'd0, hold_idx});
                check("stall_hold_valid", {63'd0, lane_out_valid}, 64'd1);
                if (c < stall_from + stall_len) begin
                    check("stall_in_ready", {63'd0, lane_in_ready}, 64'd0);
                end
            end
            hold_data = lane_out;
            hold_idx  = lane_out_idx;
            stalled_prev = (c >= stall_from) && (c < stall_from + stall_len) && lane_out_valid;
            lane_out_ready = !((c >= stall_from) && (c < stall_from + stall_len));
            lane_in_valid  = (li < 25);
            lane_in        = {$urandom, $urandom};
            step();
            if (acc_flag) li++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("pass_busy_at_done", {63'd0, busy}, 64'd0);
                end
            end
            if (done_cyc >= 0 && cyc > done_cyc + 2) break;
        end
        lane_in_valid = 1'b0;
        lane_out_ready = 1'b1;
        check("pass_done_pulses", done_cnt, 1);
        check("pass_done_timing", done_cyc, hs_cyc + 1);
        check("pass_out_count", out_count, 25);
        check("pass_sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int done_cnt;
        int done_cyc;
        rst = 1'b1; start = 1'b0; lane_in = '0; lane_in_valid = 1'b0; lane_out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // lane_in_valid in IDLE must not be consumed
        lane_in_valid = 1'b1;
        lane_in = 64'h1234_5678_9ABC_DEF0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle_in_ready", {63'd0, lane_in_ready}, 64'd0);
            check("idle_out_valid", {63'd0, lane_out_valid}, 64'd0);
        end
        lane_in_valid = 1'b0;

        // Full-rate pass with directed lanes; start re-pulsed during RUN
        for (int i = 0; i < 25; i++) lanes[i] = {$urandom, $urandom};
        lanes[0]  = 64'h0000_0000_0000_0001;
        lanes[1]  = 64'h8000_0000_0000_0000;
        lanes[12] = 64'hDEAD_BEEF_0123_4567;
        out_count = 0; cnt_model = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_ready", {63'd0, lane_in_ready}, 64'd1);
        check("start_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 25; i++) begin
            lane_in = lanes[i];
            lane_in_valid = 1'b1;
            start = (i == 5);
            step();
            check("full_rate_accept", {63'd0, acc_flag}, 64'd1);
            check("full_rate_valid", {63'd0, lane_out_valid}, 64'd1);
            check("full_rate_idx", {59'd0, lane_out_idx}, i);
            if (i == 0) check("lane0_rot21", lane_out, 64'h0000_0000_0020_0000);
            if (i == 1) check("lane1_wrap", lane_out, 64'h0000_0000_0000_0080);
            if (i == 12) check("lane12_passthru", lane_out, 64'hDEAD_BEEF_0123_4567);
        end
        lane_in_valid = 1'b0;
        start = 1'b0;
        done_cnt = 0; done_cyc = -1;
        for (int k = 0; k < 8; k++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("full_busy_at_done", {63'd0, busy}, 64'd0);
                end
            end
            step();
        end
        check("full_done_pulses", done_cnt, 1);
        check("full_done_timing", done_cyc, hs_cyc + 1);
        check("full_out_count", out_count, 25);
        check("full_sb_empty", sb_q.size(), 0);

        // Backpressure: downstream stalls 5 cycles mid-pass
        run_pass(8, 5);

        // Reset after lane 10 accepted
        out_count = 0; cnt_model = 0; sb_q.delete();
        lane_out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && cnt_model < 11; c++) begin
            lane_in = {$urandom, $urandom};
            lane_in_valid = 1'b1;
            step();
        end
        lane_in_valid = 1'b0;
        check("pre_reset_cnt", cnt_model, 11);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        sb_q.delete();
        cnt_model = 0;
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("post_reset_no_done", {63'd0, done}, 64'd0);
            check("post_reset_idle", {63'd0, busy}, 64'd0);
        end

        // Fresh pass after reset must restart at lane 0
        run_pass(1000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
